// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, error-FSM state type and
// transfer decode helpers (active transfer, byte enables, size/alignment error).
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } err_st_t;

  function automatic logic htrans_active(input logic [1:0] t);
    logic r;
    r = 1'b0;
    unique case (t)
      HTRANS_IDLE, HTRANS_BUSY: r = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic size_err(
    input logic [2:0] size,
    input logic [1:0] a
  );
    return (size > HSIZE_WORD)
      || (size == HSIZE_HALF && a[0])
      || (size == HSIZE_WORD && a != 2'b00);
  endfunction

  function automatic logic [3:0] be_calc(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] r;
    r = 4'h0;
    if (size == HSIZE_BYTE)
      r = 4'b0001 << a;
    else if (size == HSIZE_HALF)
      r = 4'b0011 << {a[1], 1'b0};
    else if (size == HSIZE_WORD)
      r = 4'hF;
    return r;
  endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// Single-entry posted-write buffer with read-forwarding merge.
// Ports: clk/rst, capture/commit controls, capture bundle, compare addr,
// raw SRAM read data in, buffer contents and merged read data out.
module ahb_sram_wbuf
  import ahb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            commit,
  input  logic [AW-1:0]   cap_addr,
  input  logic [DW/8-1:0] cap_be,
  input  logic [DW-1:0]   cap_data,
  input  logic [AW-1:0]   cmp_addr,
  input  logic [DW-1:0]   rdata,
  output logic            valid,
  output logic [AW-1:0]   addr,
  output logic [DW/8-1:0] be,
  output logic [DW-1:0]   data,
  output logic [DW-1:0]   merged
);

  localparam int BW = DW / 8;

  logic hit;

  // Capture wins over commit: a commit in the
  // same cycle has already drained the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      be    <= '0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= cap_addr;
      be    <= cap_be;
      data  <= cap_data;
    end else if (commit) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == cmp_addr);

  always_comb begin
    merged = rdata;
    for (int i = 0; i < BW; i++) begin
      if (hit && be[i])
        merged[8*i +: 8] = data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave bridging to a single-port synchronous SRAM.
// Ports: HCLK/HRESET, AHB-lite slave bus, SRAM strobe/we/be/addr/wdata/rdata.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int MEM_AW = 12
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DW-1:0]     HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DW-1:0]     HRDATA,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [DW/8-1:0]   sram_be,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [DW-1:0]     sram_wdata,
  input  logic [DW-1:0]     sram_rdata
);

  localparam int BW = DW / 8;

  err_st_t state;

  logic active;
  logic accept;
  logic bad;
  logic acc_ok;
  logic err_acc;
  logic rd_go;
  logic rd_req;
  logic stall;
  logic rdy;
  logic commit;
  logic capture;

  logic [MEM_AW-1:0] waddr;
  logic [BW-1:0]     be;

  logic              dp_read;
  logic              dp_write;
  logic [MEM_AW-1:0] dp_addr;
  logic [BW-1:0]     dp_be;

  logic              buf_valid;
  logic [MEM_AW-1:0] buf_addr;
  logic [BW-1:0]     buf_be;
  logic [DW-1:0]     buf_data;
  logic [DW-1:0]     merged;

  // Upper address bits alias onto the SRAM.
  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:MEM_AW+2];

  assign active  = htrans_active(HTRANS);
  assign accept  = HSEL & HREADY & active;
  assign bad     = size_err(HSIZE, HADDR[1:0]);
  assign acc_ok  = accept & ~bad;
  assign err_acc = accept & bad;
  assign rd_go   = acc_ok & ~HWRITE;
  assign waddr   = HADDR[MEM_AW+1:2];
  assign be      = BW'(be_calc(HSIZE, HADDR[1:0]));

  // A read request landing while a write is in data phase
  // and the buffer is full would leave no slot for the
  // new write; hold one cycle so the buffer drains.
  assign rd_req  = HSEL & active & ~HWRITE;
  assign stall   = dp_write & buf_valid & rd_req;
  assign rdy     = (state != ST_ERR1) & ~stall;

  assign commit  = buf_valid & ~rd_go;
  assign capture = dp_write & rdy;

  assign HREADYOUT = HRESET | rdy;
  assign HRESP     = (HRESET || state == ST_OKAY)
                     ? HRESP_OKAY : HRESP_ERROR;
  assign HRDATA    = (dp_read & ~HRESET) ? merged : '0;

  assign sram_cs    = ~HRESET & (rd_go | commit);
  assign sram_we    = ~rd_go;
  assign sram_addr  = rd_go ? waddr : buf_addr;
  assign sram_be    = rd_go ? '1 : buf_be;
  assign sram_wdata = buf_data;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_OKAY;
      dp_read  <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_be    <= '0;
    end else begin
      unique case (state)
        ST_OKAY: if (err_acc) state <= ST_ERR1;
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= err_acc ? ST_ERR1 : ST_OKAY;
        default: state <= ST_OKAY;
      endcase
      if (HREADY) begin
        dp_read  <= rd_go;
        dp_write <= acc_ok & HWRITE;
        if (acc_ok) begin
          dp_addr <= waddr;
          dp_be   <= be;
        end
      end
    end
  end

  ahb_sram_wbuf #(
    .DW (DW),
    .AW (MEM_AW)
  ) u_wbuf (
    .clk      (HCLK),
    .rst      (HRESET),
    .capture  (capture),
    .commit   (commit),
    .cap_addr (dp_addr),
    .cap_be   (dp_be),
    .cap_data (HWDATA),
    .cmp_addr (dp_addr),
    .rdata    (sram_rdata),
    .valid    (buf_valid),
    .addr     (buf_addr),
    .be       (buf_be),
    .data     (buf_data),
    .merged   (merged)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave with a behavioural SRAM.
// Ports: none (top-level bench).
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        sram_cs;
  logic        sram_we;
  logic [3:0]  sram_be;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [31:0] mem [0:4095];

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  ahb_sram_slave #(.DW(32), .MEM_AW(12)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always @(posedge HCLK) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
        wr_cnt = wr_cnt + 1;
      end else begin
        sram_rdata <= mem[sram_addr];
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic drv(input logic sel, input logic [1:0] tr,
                     input logic wr, input logic [31:0] a,
                     input logic [2:0] sz);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz;
  endtask

  task automatic idle();
    drv(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD);
  endtask

  task automatic test_reset();
    drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD);
    smp();
    checks++;
    if ({HREADYOUT, HRESP, HRDATA, sram_cs} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_out got=%h exp=%h", {HREADYOUT, HRESP, HRDATA, sram_cs}, {1'b1, 1'b0, 32'h0, 1'b0});
    end
    step(); idle(); smp();
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", HRDATA);
    end
    step(); HRESET = 1'b0; smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b100) begin
      errors++; $display("FAIL reset_release got=%b exp=100", {HREADYOUT, HRESP, sram_cs});
    end
  endtask

  task automatic test_word_rw();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h100, HSIZE_WORD); smp();
    checks++;
    if ({HREADYOUT, sram_cs} !== 2'b10) begin
      errors++; $display("FAIL rw_addr got=%b exp=10", {HREADYOUT, sram_cs});
    end
    step(); idle(); HWDATA = 32'hCAFEF00D; smp();
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++; $display("FAIL rw_wdp_rdy got=%b exp=1", HREADYOUT);
    end
    step(); smp();
    checks++;
    if ({sram_cs, sram_we, sram_addr, sram_be, sram_wdata} !== {1'b1, 1'b1, 12'h040, 4'hF, 32'hCAFEF00D}) begin
      errors++; $display("FAIL rw_commit got=%h exp=%h", {sram_cs, sram_we, sram_addr, sram_be, sram_wdata}, {1'b1, 1'b1, 12'h040, 4'hF, 32'hCAFEF00D});
    end
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD); smp();
    checks++;
    if ({sram_cs, sram_we, sram_addr, HREADYOUT} !== {1'b1, 1'b0, 12'h040, 1'b1}) begin
      errors++; $display("FAIL rw_rd_strobe got=%h exp=%h", {sram_cs, sram_we, sram_addr, HREADYOUT}, {1'b1, 1'b0, 12'h040, 1'b1});
    end
    step(); idle(); smp();
    checks++;
    if ({HRDATA, HREADYOUT} !== {32'hCAFEF00D, 1'b1}) begin
      errors++; $display("FAIL rw_rdata got=%h exp=%h", {HRDATA, HREADYOUT}, {32'hCAFEF00D, 1'b1});
    end
    checks++;
    if ((wr_cnt - w0) != 1 || (rd_cnt - r0) != 1) begin
      errors++; $display("FAIL rw_counts got=%0d/%0d exp=1/1", wr_cnt - w0, rd_cnt - r0);
    end
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0001_0100, HSIZE_WORD); smp();
    checks++;
    if ({sram_cs, sram_addr} !== {1'b1, 12'h040}) begin
      errors++; $display("FAIL alias_addr got=%h exp=%h", {sram_cs, sram_addr}, {1'b1, 12'h040});
    end
    step(); idle(); smp();
    checks++;
    if (HRDATA !== 32'hCAFEF00D) begin
      errors++; $display("FAIL alias_rdata got=%h exp=cafef00d", HRDATA);
    end
    step(); smp();
    checks++;
    if ({HRDATA, sram_cs} !== {32'h0, 1'b0}) begin
      errors++; $display("FAIL rw_idle got=%h exp=0", {HRDATA, sram_cs});
    end
  endtask

  task automatic test_forward();
    mem[4] = 32'hDEADBEEF;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD); smp();
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD);
    HWDATA = 32'h11223344; smp();
    checks++;
    if ({HREADYOUT, sram_cs, sram_we, sram_addr} !== {1'b1, 1'b1, 1'b0, 12'h004}) begin
      errors++; $display("FAIL fwd_rd_strobe got=%h exp=%h", {HREADYOUT, sram_cs, sram_we, sram_addr}, {1'b1, 1'b1, 1'b0, 12'h004});
    end
    step(); idle(); smp();
    checks++;
    if (HRDATA !== 32'h11223344) begin
      errors++; $display("FAIL fwd_rdata got=%h exp=11223344", HRDATA);
    end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fwd_sram_old got=%h exp=deadbeef", mem[4]);
    end
    checks++;
    if ({sram_cs, sram_we, sram_addr, sram_wdata} !== {1'b1, 1'b1, 12'h004, 32'h11223344}) begin
      errors++; $display("FAIL fwd_commit got=%h exp=%h", {sram_cs, sram_we, sram_addr, sram_wdata}, {1'b1, 1'b1, 12'h004, 32'h11223344});
    end
    step(); smp();
    checks++;
    if (mem[4] !== 32'h11223344) begin
      errors++; $display("FAIL fwd_sram_new got=%h exp=11223344", mem[4]);
    end
  endtask

  task automatic test_byte_merge();
    mem[8] = 32'h55555555;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD); smp();
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h22, HSIZE_BYTE);
    HWDATA = 32'h0; smp();
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++; $display("FAIL bm_rdy got=%b exp=1", HREADYOUT);
    end
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD);
    HWDATA = 32'h00AB0000; smp();
    checks++;
    if ({HREADYOUT, sram_cs, sram_we, sram_addr, sram_be, sram_wdata} !== {1'b0, 1'b1, 1'b1, 12'h008, 4'hF, 32'h0}) begin
      errors++; $display("FAIL bm_stall got=%h exp=%h", {HREADYOUT, sram_cs, sram_we, sram_addr, sram_be, sram_wdata}, {1'b0, 1'b1, 1'b1, 12'h008, 4'hF, 32'h0});
    end
    step(); smp();
    checks++;
    if ({HREADYOUT, sram_cs, sram_we, sram_addr} !== {1'b1, 1'b1, 1'b0, 12'h008}) begin
      errors++; $display("FAIL bm_rd_strobe got=%h exp=%h", {HREADYOUT, sram_cs, sram_we, sram_addr}, {1'b1, 1'b1, 1'b0, 12'h008});
    end
    step(); idle(); smp();
    checks++;
    if (HRDATA !== 32'h00AB0000) begin
      errors++; $display("FAIL bm_merge got=%h exp=00ab0000", HRDATA);
    end
    checks++;
    if ({sram_cs, sram_we, sram_be} !== {1'b1, 1'b1, 4'b0100}) begin
      errors++; $display("FAIL bm_byte_be got=%h exp=%h", {sram_cs, sram_we, sram_be}, {1'b1, 1'b1, 4'b0100});
    end
    step(); smp();
    checks++;
    if (mem[8] !== 32'h00AB0000) begin
      errors++; $display("FAIL bm_sram got=%h exp=00ab0000", mem[8]);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    mem[12'h082] = 32'h0C0C0C0C;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h200, HSIZE_WORD); smp();
    if (!HREADYOUT) stalls++;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h204, HSIZE_WORD);
    HWDATA = 32'hA1A2A3A4; smp();
    if (!HREADYOUT) stalls++;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h208, HSIZE_WORD);
    HWDATA = 32'hB1B2B3B4; smp();
    if (!HREADYOUT) stalls++;
    checks++;
    if ({sram_cs, sram_we, sram_addr, sram_wdata} !== {1'b1, 1'b1, 12'h080, 32'hA1A2A3A4}) begin
      errors++; $display("FAIL b2b_commit_a got=%h exp=%h", {sram_cs, sram_we, sram_addr, sram_wdata}, {1'b1, 1'b1, 12'h080, 32'hA1A2A3A4});
    end
    step(); smp();
    if (!HREADYOUT) stalls++;
    step(); idle(); smp();
    if (!HREADYOUT) stalls++;
    checks++;
    if (HRDATA !== 32'h0C0C0C0C) begin
      errors++; $display("FAIL b2b_read_c got=%h exp=0c0c0c0c", HRDATA);
    end
    checks++;
    if (stalls != 1) begin
      errors++; $display("FAIL b2b_stalls got=%0d exp=1", stalls);
    end
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h200, HSIZE_WORD); smp();
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h204, HSIZE_WORD); smp();
    checks++;
    if (HRDATA !== 32'hA1A2A3A4) begin
      errors++; $display("FAIL b2b_read_a got=%h exp=a1a2a3a4", HRDATA);
    end
    step(); idle(); smp();
    checks++;
    if (HRDATA !== 32'hB1B2B3B4) begin
      errors++; $display("FAIL b2b_read_b got=%h exp=b1b2b3b4", HRDATA);
    end
  endtask

  task automatic test_half();
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h402, HSIZE_HALF); smp();
    step(); idle(); HWDATA = 32'hBEEF0000; smp();
    step(); smp();
    checks++;
    if ({sram_cs, sram_we, sram_addr, sram_be} !== {1'b1, 1'b1, 12'h100, 4'b1100}) begin
      errors++; $display("FAIL half_commit got=%h exp=%h", {sram_cs, sram_we, sram_addr, sram_be}, {1'b1, 1'b1, 12'h100, 4'b1100});
    end
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h400, HSIZE_WORD); smp();
    step(); idle(); smp();
    checks++;
    if (HRDATA !== 32'hBEEF0000) begin
      errors++; $display("FAIL half_rdata got=%h exp=beef0000", HRDATA);
    end
  endtask

  task automatic test_idle_busy();
    step(); drv(1'b1, HTRANS_BUSY, 1'b0, 32'h100, HSIZE_WORD); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b100) begin
      errors++; $display("FAIL busy_resp got=%b exp=100", {HREADYOUT, HRESP, sram_cs});
    end
    step(); drv(1'b1, HTRANS_IDLE, 1'b1, 32'h104, HSIZE_WORD); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs, HRDATA} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL idle_resp got=%h exp=%h", {HREADYOUT, HRESP, sram_cs, HRDATA}, {3'b100, 32'h0});
    end
    step(); idle(); smp();
    checks++;
    if ({sram_cs, HRDATA} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL idle_after got=%h exp=0", {sram_cs, HRDATA});
    end
  endtask

  task automatic test_error();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h3, HSIZE_HALF); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b100) begin
      errors++; $display("FAIL err_addr got=%b exp=100", {HREADYOUT, HRESP, sram_cs});
    end
    step(); idle(); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b010) begin
      errors++; $display("FAIL err1 got=%b exp=010", {HREADYOUT, HRESP, sram_cs});
    end
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h2, HSIZE_WORD); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b110) begin
      errors++; $display("FAIL err2 got=%b exp=110", {HREADYOUT, HRESP, sram_cs});
    end
    step(); idle(); HWDATA = 32'hFFFFFFFF; smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b010) begin
      errors++; $display("FAIL err2_to_err1 got=%b exp=010", {HREADYOUT, HRESP, sram_cs});
    end
    step(); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b110) begin
      errors++; $display("FAIL err2_b got=%b exp=110", {HREADYOUT, HRESP, sram_cs});
    end
    step(); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b100) begin
      errors++; $display("FAIL err_okay got=%b exp=100", {HREADYOUT, HRESP, sram_cs});
    end
    step(); drv(1'b1, HTRANS_SEQ, 1'b0, 32'h8, 3'b011); smp();
    step(); idle(); smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs} !== 3'b010) begin
      errors++; $display("FAIL err_size got=%b exp=010", {HREADYOUT, HRESP, sram_cs});
    end
    step(); smp(); step(); smp();
    checks++;
    if ({HREADYOUT, HRESP} !== 2'b10) begin
      errors++; $display("FAIL err_size_end got=%b exp=10", {HREADYOUT, HRESP});
    end
    checks++;
    if (wr_cnt != w0 || rd_cnt != r0) begin
      errors++; $display("FAIL err_no_access got=%0d/%0d exp=%0d/%0d", wr_cnt, rd_cnt, w0, r0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    mem[12'h0C0] = 32'h12345678;
    w0 = wr_cnt;
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b1, 32'h300, HSIZE_WORD); smp();
    step(); idle(); HRESET = 1'b1; HWDATA = 32'hFFFFFFFF; smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs, HRDATA} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL rst_mid_in got=%h exp=%h", {HREADYOUT, HRESP, sram_cs, HRDATA}, {3'b100, 32'h0});
    end
    step(); HRESET = 1'b0; smp();
    checks++;
    if ({HREADYOUT, HRESP, sram_cs, HRDATA} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL rst_mid_after got=%h exp=%h", {HREADYOUT, HRESP, sram_cs, HRDATA}, {3'b100, 32'h0});
    end
    step(); smp(); step(); smp();
    checks++;
    if (wr_cnt != w0 || mem[12'h0C0] !== 32'h12345678) begin
      errors++; $display("FAIL rst_mid_nowrite got=%0d/%h exp=%0d/12345678", wr_cnt, mem[12'h0C0], w0);
    end
    step(); drv(1'b1, HTRANS_NONSEQ, 1'b0, 32'h300, HSIZE_WORD); smp();
    step(); idle(); smp();
    checks++;
    if (HRDATA !== 32'h12345678) begin
      errors++; $display("FAIL rst_mid_read got=%h exp=12345678", HRDATA);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    sram_rdata = 32'h0;
    HRESET = 1'b1;
    HWDATA = 32'h0;
    idle();
    step();
    test_reset();
    test_word_rw();
    test_forward();
    test_byte_merge();
    test_back_to_back();
    test_half();
    test_idle_busy();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
